// File: rtl/alu_sequencer.sv
// Instruction sequencer for an external combinational 8-bit ALU.
// Holds a 4x8 register file, iterates each op rep+1 times and writes results and flags back.
module alu_sequencer #(
  parameter int NREG = 4,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ins_valid,
  output logic         ins_ready,
  input  logic [7:0]   ins_word,
  input  logic         ld_en,
  input  logic [1:0]   ld_addr,
  input  logic [W-1:0] ld_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  input  logic         alu_co,
  input  logic         alu_z,
  output logic [W-1:0] result,
  output logic         co_flag,
  output logic         z_flag,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [W-1:0] regs [0:NREG-1];
  logic [1:0]   op;
  logic [1:0]   rd;
  logic [1:0]   rs;
  logic [1:0]   cnt;
  logic         accept;
  logic         last_iter;

  assign accept    = (state == IDLE) && ins_valid && !ld_en;
  assign last_iter = (cnt == 2'd0);

  // Operands are read live from the register file so rd==rs sees each iteration's update.
  assign alu_a   = regs[rd];
  assign alu_b   = regs[rs];
  assign alu_sel = op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ins_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ins_ready = !ld_en;
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      op      <= 2'd0;
      rd      <= 2'd0;
      rs      <= 2'd0;
      cnt     <= 2'd0;
      result  <= '0;
      co_flag <= 1'b0;
      z_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A load takes priority; the pending instruction is held by its source.
          if (ld_en) begin
            regs[ld_addr] <= ld_data;
          end else if (ins_valid) begin
            op  <= ins_word[7:6];
            rd  <= ins_word[5:4];
            rs  <= ins_word[3:2];
            cnt <= ins_word[1:0];
          end
        end
        EXEC: begin
          regs[rd] <= alu_out;
          co_flag  <= alu_co;
          z_flag   <= alu_z;
          if (last_iter) begin
            result <= alu_out;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the external ALU.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ins_valid;
  logic       ins_ready;
  logic [7:0] ins_word;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_co;
  logic       alu_z;
  logic [7:0] result;
  logic       co_flag;
  logic       z_flag;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_word(ins_word), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_co(alu_co), .alu_z(alu_z), .result(result), .co_flag(co_flag),
    .z_flag(z_flag), .done(done)
  );

  // External ALU: AND, XOR, ADD (carry out), CLS (rotate left, msb to carry).
  logic [8:0] sum;
  always_comb begin
    sum     = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out = 8'h00;
    alu_co  = 1'b0;
    case (alu_sel)
      2'd0: alu_out = alu_a & alu_b;
      2'd1: alu_out = alu_a ^ alu_b;
      2'd2: begin alu_out = sum[7:0]; alu_co = sum[8]; end
      default: begin alu_out = {alu_a[6:0], alu_a[7]}; alu_co = alu_a[7]; end
    endcase
    alu_z = (alu_out == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Counts edges from the accept edge (1) until done is seen; expects rep+2.
  task automatic run_ins(input logic [7:0] word, input int rep, input string tag);
    int lat;
    @(negedge clk);
    ins_valid = 1'b1; ins_word = word;
    #1 check({tag, " ready"}, ins_ready, 1);
    @(posedge clk); #1;
    ins_valid = 1'b0; ins_word = 8'hFF;
    lat = 1;
    check({tag, " busy"}, ins_ready, 0);
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, rep + 2);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle ready"}, ins_ready, 1);
  endtask

  logic [7:0] cls_seq [4] = '{8'h03, 8'h06, 8'h0C, 8'h18};
  logic       cls_co  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst = 1'b1; ins_valid = 1'b0; ins_word = 8'h00;
    ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst result", result, 8'h00);
    check("rst done", done, 0);
    check("rst flags", {co_flag, z_flag}, 2'b00);
    check("rst alu_sel", alu_sel, 2'd0);
    check("rst alu_a", alu_a, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // 1: AND R0,R1
    load(2'd0, 8'h0F);
    load(2'd1, 8'h3C);
    run_ins(8'h04, 0, "and");
    check("and result", result, 8'h0C);
    check("and flags", {co_flag, z_flag}, 2'b00);

    // 2: ADD R2,R3 with carry out
    load(2'd2, 8'hF0);
    load(2'd3, 8'h20);
    run_ins(8'hAC, 0, "add");
    check("add result", result, 8'h10);
    check("add flags", {co_flag, z_flag}, 2'b10);

    // 3: XOR R0,R0 gives zero
    load(2'd0, 8'h55);
    run_ins(8'h40, 0, "xor");
    check("xor result", result, 8'h00);
    check("xor flags", {co_flag, z_flag}, 2'b01);

    // 4: CLS R1 four times; loads leave flags/result untouched
    load(2'd1, 8'h81);
    check("load keeps flags", {co_flag, z_flag}, 2'b01);
    check("load keeps result", result, 8'h00);
    @(negedge clk);
    ins_valid = 1'b1; ins_word = 8'hD7;
    @(posedge clk); #1;
    ins_valid = 1'b0; ins_word = 8'hFF;
    check("cls a0", alu_a, 8'h81);
    check("cls sel", alu_sel, 2'd3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("cls r1[%0d]", i), alu_a, cls_seq[i]);
      check($sformatf("cls co[%0d]", i), co_flag, cls_co[i]);
      check($sformatf("cls done[%0d]", i), done, (i == 3) ? 1 : 0);
    end
    check("cls result", result, 8'h18);
    @(posedge clk); #1;
    check("cls done pulse", done, 0);

    // 5: load beats instruction in IDLE; load ignored during EXEC
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h07;
    ins_valid = 1'b1; ins_word = 8'hA8;
    #1 check("ld blocks ready", ins_ready, 0);
    @(posedge clk); #1;
    check("ld no accept", ins_ready, 0);
    check("ld no done", done, 0);
    @(negedge clk);
    ld_en = 1'b0;
    #1 check("ready after ld", ins_ready, 1);
    @(posedge clk); #1;
    ins_valid = 1'b0; ins_word = 8'hFF;
    check("exec a=R2", alu_a, 8'h07);
    check("exec b=R2", alu_b, 8'h07);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hEE;
    @(posedge clk); #1;
    check("rdrs done", done, 1);
    check("rdrs result", result, 8'h0E);
    @(negedge clk);
    ld_en = 1'b0;
    @(posedge clk); #1;
    check("exec ld ignored", alu_a, 8'h0E);

    // 6: reset in the middle of ADD rep3
    load(2'd0, 8'hFF);
    load(2'd1, 8'h01);
    @(negedge clk);
    ins_valid = 1'b1; ins_word = 8'h87;
    @(posedge clk); #1;
    ins_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-rst co", co_flag, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst alu_a", alu_a, 8'h00);
    check("mid rst alu_b", alu_b, 8'h00);
    check("mid rst result", result, 8'h00);
    check("mid rst flags", {co_flag, z_flag}, 2'b00);
    check("mid rst sel", alu_sel, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("no done after rst", seen, 0);
    check("idle after rst", ins_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
